// File: rtl/lsu_arbiter_if.sv
// Requester/LSU-side bundle for lsu_arbiter: two request ports, the shared
// response path and the single LSU access port.
interface lsu_arbiter_if;
    // Handshake: a port holds i_reqN and its fields stable until it sees o_gntN
    // (one-cycle pulse); it may drop or change the request from the next cycle.
    // o_rvalidN is a one-cycle pulse qualifying the shared o_rdata for port N.
    logic        i_req0;
    logic        i_req1;
    logic [31:0] i_addr0;
    logic [31:0] i_addr1;
    logic        i_wren0;
    logic        i_wren1;
    logic [3:0]  i_mask0;
    logic [3:0]  i_mask1;
    logic        i_un0;
    logic        i_un1;
    logic [31:0] i_wdata0;
    logic [31:0] i_wdata1;

    logic        o_gnt0;
    logic        o_gnt1;
    logic        o_rvalid0;
    logic        o_rvalid1;
    logic [31:0] o_rdata;

    logic [31:0] o_lsu_addr;
    logic [3:0]  o_lsu_mask;
    logic        o_lsu_un;
    logic        o_lsu_wren;
    logic        o_lsu_rden;
    logic [31:0] o_st_data;
    logic [31:0] i_ld_data;

    logic        o_busy;

    modport slave (
        input  i_req0, i_req1, i_addr0, i_addr1, i_wren0, i_wren1,
        input  i_mask0, i_mask1, i_un0, i_un1, i_wdata0, i_wdata1,
        input  i_ld_data,
        output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
        output o_lsu_addr, o_lsu_mask, o_lsu_un, o_lsu_wren, o_lsu_rden,
        output o_st_data, o_busy
    );

    modport master (
        output i_req0, i_req1, i_addr0, i_addr1, i_wren0, i_wren1,
        output i_mask0, i_mask1, i_un0, i_un1, i_wdata0, i_wdata1,
        output i_ld_data,
        input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
        input  o_lsu_addr, o_lsu_mask, o_lsu_un, o_lsu_wren, o_lsu_rden,
        input  o_st_data, o_busy
    );
endinterface

// File: rtl/lsu_arbiter.sv
// Two-port round-robin arbiter in front of the single LSU port: one access at a
// time, one-cycle LSU strobe, load data returned after RD_LAT cycles.
module lsu_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    lsu_arbiter_if.slave     bus,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] LAST_WAIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    logic [1:0]  state;
    logic [1:0]  wait_cnt;
    logic        prio;
    logic        sel;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [3:0]  mask_q;
    logic        un_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        any_req;
    logic        win;

    // A lone requester wins outright; on contention the priority holder wins.
    always_comb begin
        any_req = bus.i_req0 | bus.i_req1;
        if (bus.i_req0 && bus.i_req1) begin
            win = prio;
        end else begin
            win = bus.i_req1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
            prio     <= 1'b0;
            sel      <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 32'd0;
            mask_q   <= 4'd0;
            un_q     <= 1'b0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel   <= win;
                        prio  <= ~win;
                        state <= ISSUE;
                        if (win) begin
                            wr_q    <= bus.i_wren1;
                            addr_q  <= bus.i_addr1;
                            mask_q  <= bus.i_mask1;
                            un_q    <= bus.i_un1;
                            wdata_q <= bus.i_wdata1;
                        end else begin
                            wr_q    <= bus.i_wren0;
                            addr_q  <= bus.i_addr0;
                            mask_q  <= bus.i_mask0;
                            un_q    <= bus.i_un0;
                            wdata_q <= bus.i_wdata0;
                        end
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        state <= IDLE;
                    end else if (RD_LAT == 0) begin
                        // Zero-latency LSU: data is valid in the rden cycle itself.
                        rdata_q <= bus.i_ld_data;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= 2'd0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        rdata_q  <= bus.i_ld_data;
                        wait_cnt <= 2'd0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from flops, so they are glitch-free one-cycle pulses.
    assign bus.o_gnt0     = (state == ISSUE) && !sel;
    assign bus.o_gnt1     = (state == ISSUE) &&  sel;
    assign bus.o_lsu_wren = (state == ISSUE) &&  wr_q;
    assign bus.o_lsu_rden = (state == ISSUE) && !wr_q;
    assign bus.o_rvalid0  = (state == RESP)  && !sel;
    assign bus.o_rvalid1  = (state == RESP)  &&  sel;
    assign bus.o_busy     = (state != IDLE);

    assign bus.o_rdata    = rdata_q;
    assign bus.o_lsu_addr = addr_q;
    assign bus.o_lsu_mask = mask_q;
    assign bus.o_lsu_un   = un_q;
    assign bus.o_st_data  = wdata_q;

    assign dbg_state      = state;

endmodule
